pkt_summary: RTL and testbench

Passive AXI-Stream tap that watches a raw packet stream and emits one 24-bit summary record per packet: byte length, port number and a bad flag. It sits directly upstream of the packet-counter/status register block. One instance drives each of that block's summary inputs (`axis_inN_*`). The block has no backpressure path in either direction: it observes the packet stream and produces fire-and-forget summary pulses.

---
 rtl/pkt_summary_if.sv | 36 +++
 rtl/pkt_summary.sv | 143 ++++++++++++++
 tb/tb_pkt_summary.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_summary_if.sv
// Packet tap bus: monitored AXI-Stream input
// and fire-and-forget summary output.
interface pkt_summary_if #(
  parameter int DW = 512
);
  logic [DW-1:0]   axis_in_tdata;
  logic [DW/8-1:0] axis_in_tkeep;
  logic            axis_in_tlast;
  logic            axis_in_tuser;
  logic            axis_in_tvalid;
  logic [23:0]     axis_out_tdata;
  logic            axis_out_tuser;
  logic            axis_out_tvalid;

  modport master (
    output axis_in_tdata,
    output axis_in_tkeep,
    output axis_in_tlast,
    output axis_in_tuser,
    output axis_in_tvalid,
    input  axis_out_tdata,
    input  axis_out_tuser,
    input  axis_out_tvalid
  );

  modport slave (
    input  axis_in_tdata,
    input  axis_in_tkeep,
    input  axis_in_tlast,
    input  axis_in_tuser,
    input  axis_in_tvalid,
    output axis_out_tdata,
    output axis_out_tuser,
    output axis_out_tvalid
  );
endinterface

// File: rtl/pkt_summary.sv
// Passive packet tap: one 24-bit record
// {port, length} plus bad flag per packet.
module pkt_summary #(
  parameter int DW          = 512,
  parameter int PORT_OFFSET = 12
) (
  input logic         clk,
  input logic         reset,
  pkt_summary_if.slave bus
);
  localparam int KW = DW / 8;
  localparam int PW = $clog2(KW + 1);

  typedef enum logic {
    FIRST,
    MID
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [16:0]   r_acc;
  logic [16:0]   w_acc_nxt;
  logic          r_bad;
  logic          w_bad_nxt;
  logic [7:0]    r_port;
  logic [7:0]    w_port_nxt;
  logic          r_vld;
  logic          w_vld_nxt;
  logic [23:0]   r_rec;
  logic [23:0]   w_rec_nxt;
  logic          r_user;
  logic          w_user_nxt;

  logic [PW-1:0] w_pop;
  logic          w_first;
  logic [16:0]   w_acc_base;
  logic [17:0]   w_sum;
  logic [16:0]   w_acc_sat;
  logic          w_ovf;
  logic          w_zero;
  logic [15:0]   w_len;
  logic          w_port_ok;
  logic [7:0]    w_port;
  logic          w_keep_full;
  logic          w_keep_contig;
  logic          w_bad_beat;
  logic          w_bad;
  logic          w_bad_fin;

  // Popcount of the byte-valid mask for this beat.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < KW; i++) begin
      w_pop = w_pop + PW'(bus.axis_in_tkeep[i]);
    end
  end

  assign w_first    = (r_state == FIRST);
  assign w_acc_base = w_first ? '0 : r_acc;
  assign w_sum      = {1'b0, w_acc_base} + 18'(w_pop);
  assign w_acc_sat  = w_sum[17] ? '1 : w_sum[16:0];
  assign w_ovf      = w_acc_sat[16];
  assign w_zero     = (w_acc_sat == '0);
  assign w_len      = w_ovf ? 16'hFFFF : w_acc_sat[15:0];

  assign w_port_ok = bus.axis_in_tkeep[PORT_OFFSET];
  assign w_port    = !w_first ? r_port :
    (w_port_ok ?
      bus.axis_in_tdata[8*PORT_OFFSET +: 8] :
      8'hFF);

  assign w_keep_full   = &bus.axis_in_tkeep;
  // A contiguous-from-bit-0 mask plus one has no bits in common with it.
  assign w_keep_contig =
    ((bus.axis_in_tkeep &
      (bus.axis_in_tkeep + KW'(1))) == '0);

  assign w_bad_beat = bus.axis_in_tuser |
    (w_first & ~w_port_ok) |
    (bus.axis_in_tlast ? ~w_keep_contig
                       : ~w_keep_full);
  assign w_bad      = (!w_first & r_bad) | w_bad_beat;
  assign w_bad_fin  = w_bad | w_ovf | w_zero;

  // Next state, per-packet accumulation and record formation.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_bad_nxt   = r_bad;
    w_port_nxt  = r_port;
    w_vld_nxt   = 1'b0;
    w_rec_nxt   = r_rec;
    w_user_nxt  = r_user;
    if (bus.axis_in_tvalid) begin
      unique case (r_state)
        FIRST: begin
          if (!bus.axis_in_tlast) begin
            w_state_nxt = MID;
          end
        end
        MID: begin
          if (bus.axis_in_tlast) begin
            w_state_nxt = FIRST;
          end
        end
      endcase
      if (bus.axis_in_tlast) begin
        w_vld_nxt  = 1'b1;
        w_rec_nxt  = {w_port, w_len};
        w_user_nxt = w_bad_fin;
      end else begin
        w_acc_nxt  = w_acc_sat;
        w_bad_nxt  = w_bad;
        w_port_nxt = w_port;
      end
    end
  end

  // State and registered outputs; reset drops any pending record.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FIRST;
      r_acc   <= '0;
      r_bad   <= 1'b0;
      r_port  <= '0;
      r_vld   <= 1'b0;
      r_rec   <= '0;
      r_user  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_bad   <= w_bad_nxt;
      r_port  <= w_port_nxt;
      r_vld   <= w_vld_nxt;
      r_rec   <= w_rec_nxt;
      r_user  <= w_user_nxt;
    end
  end

  assign bus.axis_out_tvalid = r_vld;
  assign bus.axis_out_tdata  = r_rec;
  assign bus.axis_out_tuser  = r_user;
endmodule

// File: tb/tb_pkt_summary.sv
// Bench for pkt_summary: directed scenarios
// plus random packets against a packet-level model.
module tb_pkt_summary;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int PO = 12;
  localparam logic [KW-1:0] FULL = '1;

  typedef struct {
    logic          r;
    logic          v;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pkt_summary_if #(.DW(DW)) bus();

  pkt_summary #(
    .DW(DW),
    .PORT_OFFSET(PO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  bit          m_in = 0;
  int          m_len;
  bit          m_bad;
  logic [7:0]  m_port;
  logic        m_vld;
  logic [23:0] m_data;
  logic        m_user;

  function automatic logic [DW-1:0] mk_data(
    input logic [7:0] port);
    logic [DW-1:0] d;
    for (int i = 0; i < KW; i++) d[8*i +: 8] = 8'($urandom);
    d[8*PO +: 8] = port;
    return d;
  endfunction

  function automatic bit contig(input logic [KW-1:0] k);
    bit seen0 = 0;
    for (int i = 0; i < KW; i++) begin
      if (!k[i]) seen0 = 1;
      else if (seen0) return 0;
    end
    return 1;
  endfunction

  function automatic beat_t bt(
    input logic r, input logic v,
    input logic [DW-1:0] d, input logic [KW-1:0] k,
    input logic l, input logic u);
    beat_t b;
    b.r = r; b.v = v; b.d = d;
    b.k = k; b.l = l; b.u = u;
    return b;
  endfunction

  function automatic beat_t idle();
    return bt(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endfunction

  // Drive one cycle and advance the packet-level model.
  task automatic step(input beat_t b);
    @(negedge clk);
    reset               = b.r;
    bus.axis_in_tvalid  = b.v;
    bus.axis_in_tdata   = b.d;
    bus.axis_in_tkeep   = b.k;
    bus.axis_in_tlast   = b.l;
    bus.axis_in_tuser   = b.u;
    @(posedge clk);
    m_vld = 1'b0;
    if (b.r) begin
      m_in = 0;
    end else if (b.v) begin
      if (!m_in) begin
        m_len  = 0;
        m_bad  = !b.k[PO];
        m_port = b.k[PO] ? b.d[8*PO +: 8] : 8'hFF;
      end
      m_len += $countones(b.k);
      if (b.u) m_bad = 1;
      if (!b.l && b.k !== FULL) m_bad = 1;
      if (b.l && !contig(b.k)) m_bad = 1;
      if (b.l) begin
        m_vld = 1'b1;
        if (m_len > 65535) begin
          m_bad  = 1;
          m_data = {m_port, 16'hFFFF};
        end else begin
          m_data = {m_port, 16'(m_len)};
        end
        if (m_len == 0) m_bad = 1;
        m_user = m_bad;
        m_in   = 0;
      end else begin
        m_in = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(bt(1'b1, 1'b0, '0, '0, 1'b0, 1'b0));
    step(bt(1'b1, 1'b1, mk_data(8'h11), FULL, 1'b1, 1'b0));
    n_vec++;
    if (bus.axis_out_tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_vld: got %b want 0", bus.axis_out_tvalid);
    end
    n_vec++;
    if (bus.axis_out_tdata !== 24'h0) begin
      n_bad++;
      $display("FAIL rst_data: got %h want 0", bus.axis_out_tdata);
    end
    n_vec++;
    if (bus.axis_out_tuser !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_user: got %b want 0", bus.axis_out_tuser);
    end
    step(idle());
  endtask

  task automatic test_full_gaps();
    beat_t q[$];
    logic [24:0] recs[$];
    for (int i = 0; i < 65; i++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) q.push_back(idle());
      q.push_back(bt(1'b0, 1'b1, mk_data(8'h03), FULL,
                     i == 64, 1'b0));
    end
    q.push_back(idle());
    q.push_back(idle());
    foreach (q[i]) begin
      step(q[i]);
      n_vec++;
      if (bus.axis_out_tvalid !== m_vld) begin
        n_bad++;
        $display("FAIL gaps_vld @%0d: got %b want %b",
                 i, bus.axis_out_tvalid, m_vld);
      end else if (m_vld) begin
        n_vec++;
        if ({bus.axis_out_tdata, bus.axis_out_tuser}
            !== {m_data, m_user}) begin
          n_bad++;
          $display("FAIL gaps_rec: got %h/%b want %h/%b",
                   bus.axis_out_tdata, bus.axis_out_tuser,
                   m_data, m_user);
        end
      end
      if (bus.axis_out_tvalid === 1'b1)
        recs.push_back({bus.axis_out_tdata, bus.axis_out_tuser});
    end
    n_vec++;
    if (recs.size() !== 1) begin
      n_bad++;
      $display("FAIL gaps_cnt: got %0d want 1", recs.size());
    end else begin
      n_vec++;
      if (recs[0] !== {24'h031040, 1'b0}) begin
        n_bad++;
        $display("FAIL gaps_val: got %h want %h",
                 recs[0], {24'h031040, 1'b0});
      end
    end
  endtask

  task automatic test_back_to_back();
    beat_t q[$];
    logic [24:0] recs[$];
    q.push_back(bt(1'b0, 1'b1, mk_data(8'h01), FULL, 1'b0, 1'b0));
    q.push_back(bt(1'b0, 1'b1, mk_data(8'h01), FULL, 1'b0, 1'b0));
    q.push_back(bt(1'b0, 1'b1, mk_data(8'h01), FULL, 1'b1, 1'b0));
    q.push_back(bt(1'b0, 1'b1, mk_data(8'h01), FULL, 1'b0, 1'b0));
    q.push_back(bt(1'b0, 1'b1, mk_data(8'h01), 64'hF, 1'b1, 1'b0));
    for (int s = 0; s < 3; s++)
      q.push_back(bt(1'b0, 1'b1, mk_data(8'(8'h20 + s)),
                     FULL >> s, 1'b1, 1'b0));
    q.push_back(idle());
    foreach (q[i]) begin
      step(q[i]);
      n_vec++;
      if (bus.axis_out_tvalid !== m_vld) begin
        n_bad++;
        $display("FAIL b2b_vld @%0d: got %b want %b",
                 i, bus.axis_out_tvalid, m_vld);
      end else if (m_vld) begin
        n_vec++;
        if ({bus.axis_out_tdata, bus.axis_out_tuser}
            !== {m_data, m_user}) begin
          n_bad++;
          $display("FAIL b2b_rec: got %h/%b want %h/%b",
                   bus.axis_out_tdata, bus.axis_out_tuser,
                   m_data, m_user);
        end
      end
      if (bus.axis_out_tvalid === 1'b1)
        recs.push_back({bus.axis_out_tdata, bus.axis_out_tuser});
    end
    n_vec++;
    if (recs.size() !== 5) begin
      n_bad++;
      $display("FAIL b2b_cnt: got %0d want 5", recs.size());
    end else begin
      n_vec++;
      if (recs[0] !== {24'h0100C0, 1'b0}) begin
        n_bad++;
        $display("FAIL b2b_p1: got %h want %h",
                 recs[0], {24'h0100C0, 1'b0});
      end
      n_vec++;
      if (recs[1] !== {24'h010044, 1'b0}) begin
        n_bad++;
        $display("FAIL b2b_p2: got %h want %h",
                 recs[1], {24'h010044, 1'b0});
      end
      n_vec++;
      if (recs[3] !== {24'h21003F, 1'b0}) begin
        n_bad++;
        $display("FAIL b2b_single: got %h want %h",
                 recs[3], {24'h21003F, 1'b0});
      end
    end
  endtask

  task automatic test_tuser();
    beat_t q[$];
    logic [24:0] recs[$];
    q.push_back(bt(1'b0, 1'b1, mk_data(8'h05), FULL, 1'b0, 1'b0));
    q.push_back(bt(1'b0, 1'b1, mk_data(8'h05), FULL, 1'b0, 1'b1));
    q.push_back(bt(1'b0, 1'b1, mk_data(8'h05), FULL, 1'b1, 1'b0));
    q.push_back(idle());
    foreach (q[i]) begin
      step(q[i]);
      n_vec++;
      if (bus.axis_out_tvalid !== m_vld) begin
        n_bad++;
        $display("FAIL tuser_vld @%0d: got %b want %b",
                 i, bus.axis_out_tvalid, m_vld);
      end
      if (bus.axis_out_tvalid === 1'b1)
        recs.push_back({bus.axis_out_tdata, bus.axis_out_tuser});
    end
    n_vec++;
    if (recs.size() !== 1 || recs[0] !== {24'h0500C0, 1'b1}) begin
      n_bad++;
      $display("FAIL tuser_rec: got %0d recs, first %h want %h",
               recs.size(), recs.size() ? recs[0] : 25'h0,
               {24'h0500C0, 1'b1});
    end
  endtask

  task automatic test_runt();
    step(bt(1'b0, 1'b1, mk_data(8'h07), 64'h3FF, 1'b1, 1'b0));
    n_vec++;
    if ({bus.axis_out_tvalid, bus.axis_out_tdata,
         bus.axis_out_tuser} !== {1'b1, 24'hFF000A, 1'b1}) begin
      n_bad++;
      $display("FAIL runt: got %b/%h/%b want 1/ff000a/1",
               bus.axis_out_tvalid, bus.axis_out_tdata,
               bus.axis_out_tuser);
    end
    step(idle());
    n_vec++;
    if (bus.axis_out_tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL runt_once: got %b want 0", bus.axis_out_tvalid);
    end
  endtask

  task automatic test_overflow();
    beat_t q[$];
    logic [24:0] recs[$];
    for (int i = 0; i < 1025; i++)
      q.push_back(bt(1'b0, 1'b1, mk_data(8'h07), FULL,
                     i == 1024, 1'b0));
    q.push_back(bt(1'b0, 1'b1, mk_data(8'h07), FULL, 1'b0, 1'b0));
    q.push_back(bt(1'b0, 1'b1, mk_data(8'h07), 64'hF, 1'b1, 1'b0));
    q.push_back(idle());
    foreach (q[i]) begin
      step(q[i]);
      n_vec++;
      if (bus.axis_out_tvalid !== m_vld) begin
        n_bad++;
        $display("FAIL ovf_vld @%0d: got %b want %b",
                 i, bus.axis_out_tvalid, m_vld);
      end
      if (bus.axis_out_tvalid === 1'b1)
        recs.push_back({bus.axis_out_tdata, bus.axis_out_tuser});
    end
    n_vec++;
    if (recs.size() !== 2) begin
      n_bad++;
      $display("FAIL ovf_cnt: got %0d want 2", recs.size());
    end else begin
      n_vec++;
      if (recs[0] !== {24'h07FFFF, 1'b1}) begin
        n_bad++;
        $display("FAIL ovf_big: got %h want %h",
                 recs[0], {24'h07FFFF, 1'b1});
      end
      n_vec++;
      if (recs[1] !== {24'h070044, 1'b0}) begin
        n_bad++;
        $display("FAIL ovf_next: got %h want %h",
                 recs[1], {24'h070044, 1'b0});
      end
    end
  endtask

  task automatic test_reset_mid();
    beat_t q[$];
    logic [24:0] recs[$];
    q.push_back(bt(1'b0, 1'b1, mk_data(8'h09), FULL, 1'b0, 1'b0));
    q.push_back(bt(1'b0, 1'b1, mk_data(8'h09), FULL, 1'b0, 1'b0));
    q.push_back(bt(1'b1, 1'b0, '0, '0, 1'b0, 1'b0));
    q.push_back(idle());
    q.push_back(bt(1'b0, 1'b1, mk_data(8'h02), FULL, 1'b0, 1'b0));
    q.push_back(bt(1'b0, 1'b1, mk_data(8'h02), 64'hF, 1'b1, 1'b0));
    q.push_back(bt(1'b1, 1'b1, mk_data(8'h04), FULL, 1'b1, 1'b0));
    q.push_back(idle());
    q.push_back(idle());
    foreach (q[i]) begin
      step(q[i]);
      n_vec++;
      if (bus.axis_out_tvalid !== m_vld) begin
        n_bad++;
        $display("FAIL rmid_vld @%0d: got %b want %b",
                 i, bus.axis_out_tvalid, m_vld);
      end
      if (bus.axis_out_tvalid === 1'b1)
        recs.push_back({bus.axis_out_tdata, bus.axis_out_tuser});
    end
    n_vec++;
    if (recs.size() !== 1 || recs[0] !== {24'h020044, 1'b0}) begin
      n_bad++;
      $display("FAIL rmid_rec: got %0d recs, first %h want %h",
               recs.size(), recs.size() ? recs[0] : 25'h0,
               {24'h020044, 1'b0});
    end
  endtask

  task automatic test_random();
    beat_t q[$];
    for (int p = 0; p < 40; p++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        logic [KW-1:0] k;
        logic last;
        int c;
        last = (b == nb - 1);
        if (last) begin
          c = $urandom_range(0, KW);
          k = (c == 0) ? '0 : FULL >> (KW - c);
          if ($urandom_range(0, 5) == 0)
            k = {$urandom, $urandom};
        end else begin
          k = ($urandom_range(0, 9) == 0) ?
              {$urandom, $urandom} : FULL;
        end
        q.push_back(bt(1'b0, 1'b1, mk_data(8'($urandom)), k, last,
                       $urandom_range(0, 15) == 0));
        if ($urandom_range(0, 3) == 0) q.push_back(idle());
      end
    end
    q.push_back(idle());
    foreach (q[i]) begin
      step(q[i]);
      n_vec++;
      if (bus.axis_out_tvalid !== m_vld) begin
        n_bad++;
        $display("FAIL rnd_vld @%0d: got %b want %b",
                 i, bus.axis_out_tvalid, m_vld);
      end else if (m_vld) begin
        n_vec++;
        if ({bus.axis_out_tdata, bus.axis_out_tuser}
            !== {m_data, m_user}) begin
          n_bad++;
          $display("FAIL rnd_rec @%0d: got %h/%b want %h/%b",
                   i, bus.axis_out_tdata, bus.axis_out_tuser,
                   m_data, m_user);
        end
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.axis_in_tvalid = 1'b0;
    bus.axis_in_tdata  = '0;
    bus.axis_in_tkeep  = '0;
    bus.axis_in_tlast  = 1'b0;
    bus.axis_in_tuser  = 1'b0;
    test_reset();
    test_full_gaps();
    test_back_to_back();
    test_tuser();
    test_runt();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
